ether_payload_unpack: RTL and testbench

Receive-side stage directly downstream of the MAC-address firewall in the Ethernet interface. Consumes the firewall's gated 2-bit stream, which begins at the EtherType field. Packs dibits into bytes, admits only frames whose EtherType matches a parameter, and strips the EtherType and the trailing 4-byte FCS. Emits payload bytes plus a per-frame completion pulse with length and error status to the message decoder.

---
 rtl/ether_pkg.sv | 16 +
 rtl/dibit_packer.sv | 42 ++++
 rtl/ether_payload_unpack.sv | 152 +++++++++++++++
 tb/tb_ether_payload_unpack.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ether_pkg.sv
// Shared constants and types for the receive-side Ethernet payload unpacker.
package ether_pkg;

    localparam logic [15:0] ETHERTYPE_DEFAULT = 16'h88B5;
    localparam int          FCS_BYTES_DEFAULT = 4;
    localparam int          LEN_W             = 16;

    typedef enum logic [2:0] {
        SYNC,
        IDLE,
        TYPE,
        PAYLOAD,
        DROP
    } state_t;

endpackage

// File: rtl/dibit_packer.sv
// Packs MSB-first dibits into bytes; the count restarts whenever the valid strobe drops.
module dibit_packer (
    input  logic       clk,
    input  logic       rst,
    input  logic       din_valid,
    input  logic [1:0] din,
    output logic       byte_valid,
    output logic [7:0] byte_out,
    output logic       partial
);

    logic [5:0] shift_q, shift_d;
    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (!din_valid) begin
            shift_d = '0;
            cnt_d   = '0;
        end else begin
            shift_d = {shift_q[3:0], din};
            cnt_d   = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // The fourth dibit completes the byte combinationally so the top sees it in the same cycle.
    assign byte_valid = din_valid && (cnt_q == 2'd3);
    assign byte_out   = {shift_q, din};
    assign partial    = (cnt_q != 2'd0);

endmodule

// File: rtl/ether_payload_unpack.sv
// Filters frames by EtherType, strips EtherType and trailing FCS, and reports per-frame length/status.
module ether_payload_unpack
    import ether_pkg::*;
#(
    parameter logic [15:0] ETHERTYPE = ETHERTYPE_DEFAULT,
    parameter int          FCS_BYTES = FCS_BYTES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             axiiv,
    input  logic [1:0]       axiid,
    output logic             axiov,
    output logic [7:0]       axiod,
    output logic             done,
    output logic [LEN_W-1:0] len,
    output logic             err
);

    localparam int FILL_W = $clog2(FCS_BYTES + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(FCS_BYTES);

    logic       pk_valid;
    logic [7:0] pk_byte;
    logic       pk_partial;

    dibit_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (axiiv),
        .din        (axiid),
        .byte_valid (pk_valid),
        .byte_out   (pk_byte),
        .partial    (pk_partial)
    );

    state_t            state_q, state_d;
    logic [7:0]        type_hi_q, type_hi_d;
    logic              got_hi_q, got_hi_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]        dline_q [FCS_BYTES];
    logic [7:0]        dline_d [FCS_BYTES];

    logic              axiov_q, axiov_d;
    logic [7:0]        axiod_q, axiod_d;
    logic              done_q, done_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              err_q, err_d;

    always_comb begin
        state_d    = state_q;
        type_hi_d  = type_hi_q;
        got_hi_d   = got_hi_q;
        fill_d     = fill_q;
        byte_cnt_d = byte_cnt_q;
        dline_d    = dline_q;
        axiov_d    = 1'b0;
        axiod_d    = axiod_q;
        done_d     = 1'b0;
        len_d      = len_q;
        err_d      = err_q;

        unique case (state_q)
            SYNC: begin
                if (!axiiv) state_d = IDLE;
            end
            IDLE: begin
                if (axiiv) begin
                    state_d    = TYPE;
                    got_hi_d   = 1'b0;
                    fill_d     = '0;
                    byte_cnt_d = '0;
                end
            end
            TYPE: begin
                if (!axiiv) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    len_d   = '0;
                    state_d = IDLE;
                end else if (pk_valid) begin
                    if (!got_hi_q) begin
                        type_hi_d = pk_byte;
                        got_hi_d  = 1'b1;
                    end else if ({type_hi_q, pk_byte} == ETHERTYPE) begin
                        state_d = PAYLOAD;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            PAYLOAD: begin
                if (!axiiv) begin
                    // Whatever is still in the delay line is the FCS and is dropped here.
                    done_d  = 1'b1;
                    len_d   = byte_cnt_q;
                    err_d   = pk_partial || (fill_q != FILL_FULL);
                    state_d = IDLE;
                end else if (pk_valid) begin
                    if (fill_q == FILL_FULL) begin
                        axiov_d = 1'b1;
                        axiod_d = dline_q[FCS_BYTES-1];
                        if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + 1'b1;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                    for (int i = FCS_BYTES - 1; i > 0; i--) dline_d[i] = dline_q[i-1];
                    dline_d[0] = pk_byte;
                end
            end
            DROP: begin
                if (!axiiv) state_d = IDLE;
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SYNC;
            type_hi_q  <= '0;
            got_hi_q   <= 1'b0;
            fill_q     <= '0;
            byte_cnt_q <= '0;
            for (int i = 0; i < FCS_BYTES; i++) dline_q[i] <= '0;
            axiov_q    <= 1'b0;
            axiod_q    <= '0;
            done_q     <= 1'b0;
            len_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_hi_q  <= type_hi_d;
            got_hi_q   <= got_hi_d;
            fill_q     <= fill_d;
            byte_cnt_q <= byte_cnt_d;
            dline_q    <= dline_d;
            axiov_q    <= axiov_d;
            axiod_q    <= axiod_d;
            done_q     <= done_d;
            len_q      <= len_d;
            err_q      <= err_d;
        end
    end

    assign axiov = axiov_q;
    assign axiod = axiod_q;
    assign done  = done_q;
    assign len   = len_q;
    assign err   = err_q;

endmodule

// File: tb/tb_ether_payload_unpack.sv
// Randomised and directed frames scored against a byte-level model of the unpacker.
module tb_ether_payload_unpack;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [15:0] len;
        logic        err;
    } done_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        axiiv = 1'b0;
    logic [1:0]  axiid = 2'b00;
    logic        axiov;
    logic [7:0]  axiod;
    logic        done;
    logic [15:0] len;
    logic        err;

    logic [7:0] exp_bytes[$];
    done_t      exp_done[$];
    int         checks = 0;
    int         fails  = 0;

    ether_payload_unpack dut (
        .clk   (clk),
        .rst   (rst),
        .axiiv (axiiv),
        .axiid (axiid),
        .axiov (axiov),
        .axiod (axiod),
        .done  (done),
        .len   (len),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: every presented byte or completion must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("axiov_with_done", {31'd0, axiov & done}, 32'd0);
            if (axiov) begin
                if (exp_bytes.size() == 0) checkOutput("unexpected_byte", {24'd0, axiod}, 32'hFFFF_FFFF);
                else checkOutput("payload_byte", {24'd0, axiod}, {24'd0, exp_bytes.pop_front()});
            end
            if (done) begin
                if (exp_done.size() == 0) checkOutput("unexpected_done", {15'd0, len, err}, 32'hFFFF_FFFF);
                else checkOutput("done_len_err", {15'd0, len, err}, {15'd0, exp_done.pop_front()});
            end
        end
    end

    // Reference model: derive the whole frame's outcome from its byte list and trailing dibits.
    task automatic modelFrame(input bq_t f, input int extra);
        int nb = f.size();
        int n;
        int emitted;
        if (nb * 4 + extra == 0) return;
        if (nb < 2) begin
            exp_done.push_back('{len: 16'd0, err: 1'b1});
            return;
        end
        if ({f[0], f[1]} != 16'h88B5) return;
        n = nb - 2;
        emitted = (n > 4) ? n - 4 : 0;
        for (int i = 0; i < emitted; i++) exp_bytes.push_back(f[2+i]);
        exp_done.push_back('{len: 16'(emitted), err: (extra != 0) || (n < 4)});
    endtask

    task automatic driveDibit(input logic v, input logic [1:0] d);
        @(posedge clk);
        #1;
        axiiv = v;
        axiid = d;
    endtask

    task automatic applyStimulus(input bq_t f, input int extra, input int gap);
        logic [7:0] b;
        for (int i = 0; i < f.size(); i++) begin
            b = f[i];
            driveDibit(1'b1, b[7:6]);
            driveDibit(1'b1, b[5:4]);
            driveDibit(1'b1, b[3:2]);
            driveDibit(1'b1, b[1:0]);
        end
        for (int i = 0; i < extra; i++) driveDibit(1'b1, 2'($urandom));
        for (int i = 0; i < gap; i++) driveDibit(1'b0, 2'($urandom));
    endtask

    task automatic runFrame(input bq_t f, input int extra, input int gap);
        modelFrame(f, extra);
        applyStimulus(f, extra, gap);
    endtask

    initial begin
        bq_t f;
        #2;
        checkOutput("reset_axiov", {31'd0, axiov}, 32'd0);
        checkOutput("reset_axiod", {24'd0, axiod}, 32'd0);
        checkOutput("reset_done",  {31'd0, done}, 32'd0);
        checkOutput("reset_len",   {16'd0, len}, 32'd0);
        checkOutput("reset_err",   {31'd0, err}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) driveDibit(1'b0, 2'b11);

        // Nominal frame: 10 payload bytes then DE AD BE EF as FCS.
        f = {8'h88, 8'hB5};
        for (int i = 1; i <= 10; i++) f.push_back(8'(i));
        f.push_back(8'hDE); f.push_back(8'hAD); f.push_back(8'hBE); f.push_back(8'hEF);
        runFrame(f, 0, 1);

        // Wrong EtherType, then the good frame after a single idle cycle.
        f[0] = 8'h08; f[1] = 8'h00;
        runFrame(f, 0, 1);
        f[0] = 8'h88; f[1] = 8'hB5;
        runFrame(f, 0, 1);

        // Six payload-phase bytes plus a partial byte.
        f = {8'h88, 8'hB5, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
        runFrame(f, 2, 1);

        // Runt frame of three dibits.
        f = {};
        runFrame(f, 3, 2);

        // Reset during payload, released while the frame is still arriving.
        f = {8'h88, 8'hB5, 8'h11, 8'h22, 8'h33};
        applyStimulus(f, 0, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("midrst_axiov", {31'd0, axiov}, 32'd0);
        checkOutput("midrst_done",  {31'd0, done}, 32'd0);
        checkOutput("midrst_len",   {16'd0, len}, 32'd0);
        repeat (3) driveDibit(1'b1, 2'($urandom));
        rst = 1'b0;
        for (int i = 0; i < 40; i++) driveDibit(1'b1, 2'($urandom));
        driveDibit(1'b0, 2'b00);

        // Back-to-back short frames: exactly FCS length, then one byte more.
        f = {8'h88, 8'hB5, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        runFrame(f, 0, 1);
        f = {8'h88, 8'hB5, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
        runFrame(f, 0, 1);

        // Randomised frames.
        for (int k = 0; k < 30; k++) begin
            int nb;
            int extra;
            nb = $urandom_range(0, 22);
            extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            f = {};
            for (int i = 0; i < nb; i++) f.push_back(8'($urandom));
            if (nb >= 2 && $urandom_range(0, 4) != 0) begin
                f[0] = 8'h88;
                f[1] = 8'hB5;
            end
            runFrame(f, extra, $urandom_range(1, 3));
        end

        repeat (10) @(posedge clk);
        checkOutput("bytes_drained", exp_bytes.size(), 32'd0);
        checkOutput("dones_drained", exp_done.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
